// File: rtl/axo_prefetch.sv
// axo_prefetch: sequential instruction prefetch buffer for the Axolotl32 core.
// Streams 32-bit words from program memory into a DEPTH-entry FIFO. A core
// read at the FIFO head address is served combinationally; any other aligned
// address flushes the buffer and restarts fetching there.
// Build option: define AXO_PREFETCH_BYPASS_EN to forward a returning word
// straight to the core when the FIFO is empty (one cycle shorter miss).
module axo_prefetch #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic [31:0] cpu_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_e;

  localparam logic [LOG_DEPTH:0]   FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  state_e               state_q;
  logic [31:0]          fifo_q [DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic [LOG_DEPTH:0]   count_d;
  logic [31:0]          head_addr_q;
  logic [31:0]          fetch_addr_q;
  logic [31:0]          mem_addr_q;
  logic                 mem_req_q;

  logic aligned;
  logic head_match;
  logic hit;
  logic flush;
  logic ack;
  logic bypass;
  logic push;
  logic pop;

  assign aligned    = (cpu_addr[1:0] == 2'b00);
  assign head_match = (cpu_addr == head_addr_q);
  assign hit        = cpu_re && aligned && (count_q != '0) && head_match;
  assign flush      = cpu_re && aligned && !head_match;
  assign ack        = mem_req_q && mem_ack;

`ifdef AXO_PREFETCH_BYPASS_EN
  // Empty FIFO and the in-flight word is exactly what the core wants.
  assign bypass = (count_q == '0) && (state_q == FETCH) && ack && cpu_re &&
                  aligned && head_match && (mem_addr_q == head_addr_q);
`else
  assign bypass = 1'b0;
`endif

  // A word acked together with a flush belongs to the old stream and is dropped.
  assign push = (state_q == FETCH) && ack && !flush && !bypass;
  assign pop  = hit;

  assign cpu_ready = hit || bypass;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // Core-side read data: FIFO head on a hit, forwarded memory word on a bypass.
  always_comb begin
    cpu_data = '0;
    if (hit) begin
      cpu_data = fifo_q[rd_ptr_q];
    end else if (bypass) begin
      cpu_data = mem_data;
    end
  end

  // Occupancy after this edge: flush empties, otherwise push/pop adjust.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (push) count_d = count_d + CNT_ONE;
      if (pop)  count_d = count_d - CNT_ONE;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Fetch FSM with registered memory request, plus head/fetch address tracking.
  // In FETCH, mem_addr_q always equals fetch_addr_q (the word being requested).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      head_addr_q  <= '0;
      fetch_addr_q <= '0;
    end else begin
      if (flush) begin
        head_addr_q <= cpu_addr;
      end else if (pop || bypass) begin
        head_addr_q <= head_addr_q + 32'd4;
      end

      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q      <= FETCH;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= cpu_addr;
            fetch_addr_q <= cpu_addr;
          end else if (count_q < FULL_CNT) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_addr_q;
          end
        end

        FETCH: begin
          if (flush) begin
            fetch_addr_q <= cpu_addr;
            if (ack) begin
              mem_addr_q <= cpu_addr;
            end else begin
              state_q <= DISCARD;
            end
          end else if (ack) begin
            fetch_addr_q <= fetch_addr_q + 32'd4;
            if (count_d < FULL_CNT) begin
              mem_addr_q <= fetch_addr_q + 32'd4;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end

        DISCARD: begin
          if (flush) begin
            fetch_addr_q <= cpu_addr;
          end
          if (ack) begin
            state_q    <= FETCH;
            mem_addr_q <= flush ? cpu_addr : fetch_addr_q;
          end
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axo_prefetch.sv
// Directed testbench for axo_prefetch: fill, sequential hits, branch flush,
// misaligned access, async reset mid-request, flush with an outstanding
// request, and address wrap. Memory model returns addr ^ 0xA5A50000.
module tb_axo_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

`ifdef AXO_PREFETCH_BYPASS_EN
  localparam int unsigned BR_LAT  = 1;
  localparam int unsigned FLO_LAT = 6;
`else
  localparam int unsigned BR_LAT  = 2;
  localparam int unsigned FLO_LAT = 7;
`endif

  axo_prefetch #(.DEPTH(4), .LOG_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_data  (cpu_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  // Program memory model: acks after 'lat' wait cycles.
  int unsigned lat = 0;
  int unsigned wait_cnt;
  assign mem_ack  = mem_req && (wait_cnt >= lat);
  assign mem_data = mem_addr ^ 32'hA5A50000;

  always @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  // Log of every acked address, and a sticky flag for the dropped 0x10 word.
  logic [31:0] acks[$];
  logic        saw_stale = 1'b0;
  always @(negedge clk) begin
    if (mem_req && mem_ack) acks.push_back(mem_addr);
    if (cpu_ready && cpu_data == 32'hA5A50010) saw_stale <= 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int base;
  int n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ack_at(input int idx);
    if (idx < acks.size()) return acks[idx];
    return 32'hDEADBEEF;
  endfunction

  // Hold a read at addr until cpu_ready; check data and cycles spent waiting.
  task automatic fetch_word(input logic [31:0] addr, input int unsigned exp_lat, input string tag);
    int unsigned waits = 0;
    @(posedge clk); #1;
    cpu_re   = 1'b1;
    cpu_addr = addr;
    @(negedge clk);
    while (!cpu_ready && waits < 20) begin
      waits++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check({tag, ".data"}, cpu_data, addr ^ 32'hA5A50000);
    check({tag, ".lat"}, waits, exp_lat);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cpu_re   = 1'b0;
    cpu_addr = '0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst.mem_req",   mem_req,   0);
    check("rst.mem_addr",  mem_addr,  0);
    check("rst.cpu_ready", cpu_ready, 0);
    check("rst.cpu_data",  cpu_data,  0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Fill with zero-wait memory
    base = acks.size();
    repeat (8) @(negedge clk);
    check("fill.n", acks.size() - base, 4);
    for (int i = 0; i < 4; i++) check("fill.addr", ack_at(base + i), i * 4);
    check("fill.req_idle", mem_req, 0);

    // Sequential hits, then refill from 0x10
    base = acks.size();
    fetch_word(32'h0, 0, "seq0");
    fetch_word(32'h4, 0, "seq1");
    fetch_word(32'h8, 0, "seq2");
    idle();
    repeat (6) @(negedge clk);
    check("seq.refill_n", acks.size() - base, 3);
    check("seq.refill_first", ack_at(base), 32'h10);
    check("seq.req_idle", mem_req, 0);

    // Branch from a full FIFO
    base = acks.size();
    fetch_word(32'h100, BR_LAT, "branch");
    fetch_word(32'h104, 0, "branch_seq");
    idle();
    check("branch.addr", ack_at(base), 32'h100);

    // Misaligned read: no flush, head unchanged
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    cpu_re   = 1'b1;
    cpu_addr = 32'h102;
    repeat (3) begin
      @(negedge clk);
      check("mis.ready", cpu_ready, 0);
      check("mis.req", mem_req, 0);
    end
    fetch_word(32'h108, 0, "mis.head");
    idle();

    // Async reset mid-request, slow memory
    lat = 3;
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 32'h8) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("arst.reach8", mem_req && mem_addr == 32'h8, 1);
    #1 rst = 1'b1;
    #1;
    check("arst.req_drop", mem_req, 0);
    check("arst.addr", mem_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    base = acks.size();
    n = 0;
    while (acks.size() == base && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("arst.restart", ack_at(base), 32'h0);

    // Flush while request at 0x10 is outstanding
    n = 0;
    while (mem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("flo.full", mem_req, 0);
    fetch_word(32'h0, 0, "flo.hit0");
    idle();
    n = 0;
    while (!(mem_req && mem_addr == 32'h10) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("flo.pending10", mem_req && mem_addr == 32'h10 && !mem_ack, 1);
    base = acks.size();
    fetch_word(32'h200, FLO_LAT, "flo.branch");
    idle();
    check("flo.dropped", ack_at(base), 32'h10);
    check("flo.next", ack_at(base + 1), 32'h200);
    check("flo.stale", saw_stale, 0);

    // Address wrap at the top of the space
    lat = 0;
    repeat (30) @(negedge clk);
    fetch_word(32'hFFFFFFFC, BR_LAT, "wrap.branch");
    fetch_word(32'h0, 0, "wrap.next");
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axo_prefetch.md
Name: axo_prefetch

Overview:
Instruction prefetch buffer between the Axolotl³² core's program port and program memory. Sequentially prefetches 32-bit words into a small FIFO while the core executes, so back-to-back instruction loads are served with zero wait. A core read at any address other than the FIFO head is treated as a branch and flushes the buffer. Core side uses the core's level-held read / ready protocol; memory side uses a single-outstanding req/ack handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
LOG_DEPTH, 2, log2(DEPTH); sizes pointers; occupancy counter is LOG_DEPTH+1 bits.

Ports:
clk  input  1  clock
rst  input  1  reset
cpu_re  input  1  core requests the instruction at cpu_addr (core prog_re)
cpu_addr  input  32  requested instruction address (core prog_addr)
cpu_ready  output  1  cpu_data valid; core latches on this clock edge (core prog_ready)
cpu_data  output  32  instruction word (core prog_data)
mem_req  output  1  fetch request to program memory
mem_addr  output  32  fetch address, word aligned
mem_ack  input  1  memory returns mem_data this cycle
mem_data  input  32  fetched word

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. Reset values: cpu_ready 0, cpu_data 0, mem_req 0, mem_addr 0; FIFO empty; head_addr 0; fetch_addr 0; state IDLE. Reset mid-request drops mem_req immediately; the abandoned transfer is not tracked.
- head_addr: address of the FIFO head word. fetch_addr: address of the next word to request.
- Hit: cpu_re && cpu_addr[1:0]==0 && count!=0 && cpu_addr==head_addr. cpu_ready = hit, combinational, same cycle. cpu_data = FIFO head when hit, else 0. On a hit edge the head is popped and head_addr += 4.
- Misaligned cpu_addr with cpu_re set: cpu_ready 0, no flush, no state change. The core raises its own fault.
- cpu_addr is ignored while cpu_re is 0.
- Flush: cpu_re && aligned && cpu_addr!=head_addr. On that edge: FIFO cleared, head_addr <= cpu_addr, fetch_addr <= cpu_addr. A flush takes priority over any pop.
- Memory handshake: mem_req and mem_addr are registered and held stable until a cycle with mem_req && mem_ack. At most one request is outstanding.
- States:
  - IDLE: mem_req 0. If count<DEPTH and there is no flush, go to FETCH with mem_addr <= fetch_addr. On a flush, go to FETCH at cpu_addr.
  - FETCH: mem_req 1. On ack, push mem_data, fetch_addr += 4. If post-edge occupancy (after push and any pop) is < DEPTH, stay in FETCH with mem_addr <= fetch_addr+4; otherwise go to IDLE.
    - Flush with no ack: go to DISCARD.
    - Flush in the same cycle as ack: the acked word is dropped; stay in FETCH with mem_addr <= cpu_addr.
  - DISCARD: mem_req 1, same address held. On ack, drop the data and go to FETCH at fetch_addr. A further flush in DISCARD only updates head_addr and fetch_addr.
- Push and pop on the same edge are legal at any occupancy. Push into a full FIFO cannot occur because a request is only issued when space exists.
- Address arithmetic wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
- Miss latency with zero-wait memory (ack in the same cycle as req): flush at cycle N, mem_req at N+1, cpu_ready at N+2.

Optional Feature:
AXO_PREFETCH_BYPASS_EN:
- Defined: when the FIFO is empty, state is FETCH, mem_ack is 1, cpu_re is 1, and cpu_addr==head_addr==mem_addr, the block asserts cpu_ready the same cycle with cpu_data = mem_data. That word is not pushed; head_addr += 4. Miss latency becomes N+1.
- Undefined: every word passes through the FIFO; miss latency is N+2.

Test Plan:
- Fill: release reset, zero-wait memory returning data = addr ^ 0xA5A50000, cpu_re 0 -> mem_addr sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, then mem_req 0 with count 4.
- Sequential hit: after fill, cpu_re with addresses 0x0, 0x4, 0x8 over 3 cycles -> cpu_ready 1 every cycle with data 0xA5A50000, 0xA5A50004, 0xA5A50008; refill requests resume at 0x10.
- Branch: FIFO holds 0x0..0xC, cpu_re at 0x100 -> flush, mem_addr 0x100 next cycle, cpu_ready with 0xA5A50100 two cycles after the flush cycle (one cycle with bypass).
- Flush during outstanding request: memory acks 3 cycles after req, request at 0x10 pending, cpu_re at 0x200 -> 0x10 data dropped, next mem_addr 0x200, cpu_data never equals 0xA5A50010.
- Misaligned: cpu_re at 0x102 -> cpu_ready stays 0, FIFO contents and head_addr unchanged.
- Async reset mid-request: rst pulse while mem_req=1 at 0x8 -> mem_req 0 immediately without a clock edge; after release, fetch restarts at 0x0.
